// File: rtl/bcd_display_feeder.sv
// bcd_display_feeder: 32-bit binary to 8-digit packed BCD (sequential double-dabble) feeding
// the seven-segment display write port. Optional raw-hex path: BCD_HEX_BYPASS_EN. Rev 1.0
`default_nettype none

module bcd_display_feeder #(
  parameter logic [26:0] MAX_MAG      = 27'd99_999_999,
  parameter int          SIGN_NEG_BIT = 0,
  parameter int          SIGN_ERR_BIT = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] Value,
  input  logic        Signed,
`ifdef BCD_HEX_BYPASS_EN
  input  logic        HexMode,
`endif
  output logic        Busy,
  output logic        Done,
  output logic        Disp_WE,
  output logic        Disp_Addr,
  output logic [31:0] Disp_WD
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONV    = 3'd1,
    S_WR_DATA = 3'd2,
    S_WR_SIGN = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [31:0] bcd_q, bcd_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic        neg_q, neg_d;
  logic        err_q, err_d;
  logic        skip_q, skip_d;

  logic        req_neg;
  logic [31:0] req_mag;
  logic        req_hex;
  logic [31:0] bcd_adj;
  logic [31:0] sign_word;

  assign req_neg = Signed & Value[31];
  assign req_mag = req_neg ? (32'd0 - Value) : Value;

`ifdef BCD_HEX_BYPASS_EN
  assign req_hex = HexMode;
`else
  assign req_hex = 1'b0;
`endif

  // Double-dabble correction: every nibble >= 5 is bumped by 3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      mag_q    <= '0;
      bcd_q    <= '0;
      bitcnt_q <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      bcd_q    <= bcd_d;
      bitcnt_q <= bitcnt_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      skip_q   <= skip_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    bcd_d    = bcd_q;
    bitcnt_d = bitcnt_q;
    neg_d    = neg_q;
    err_d    = err_q;
    skip_d   = skip_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          bitcnt_d = '0;
          state_d  = S_CONV;
          if (req_hex) begin
            mag_d  = '0;
            bcd_d  = Value;
            neg_d  = 1'b0;
            err_d  = 1'b0;
            skip_d = 1'b1;
          end else begin
            mag_d  = req_mag;
            bcd_d  = '0;
            neg_d  = req_neg;
            err_d  = (req_mag > 32'(MAX_MAG));
            skip_d = (req_mag > 32'(MAX_MAG));
          end
        end
      end
      S_CONV: begin
        // Overflow and raw-hex requests spend a single cycle here with the data untouched.
        if (skip_q) begin
          state_d = S_WR_DATA;
        end else begin
          bcd_d    = {bcd_adj[30:0], mag_q[31]};
          mag_d    = {mag_q[30:0], 1'b0};
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd31)
            state_d = S_WR_DATA;
        end
      end
      S_WR_DATA: state_d = S_WR_SIGN;
      S_WR_SIGN: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sign_word               = '0;
    sign_word[SIGN_NEG_BIT] = neg_q & ~err_q;
    sign_word[SIGN_ERR_BIT] = err_q;
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign Disp_WE   = (state_q == S_WR_DATA) || (state_q == S_WR_SIGN);
  assign Disp_Addr = (state_q == S_WR_SIGN);
  assign Disp_WD   = (state_q == S_WR_DATA) ? bcd_q :
                     (state_q == S_WR_SIGN) ? sign_word : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_feeder.sv
// Scoreboard bench for bcd_display_feeder: decimal reference model, queued expectations,
// independent write/Done monitor.
`default_nettype none

module tb_bcd_display_feeder;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [31:0] Value;
  logic        Signed;
`ifdef BCD_HEX_BYPASS_EN
  logic        HexMode;
`endif
  logic        Busy;
  logic        Done;
  logic        Disp_WE;
  logic        Disp_Addr;
  logic [31:0] Disp_WD;

  bcd_display_feeder dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Value     (Value),
    .Signed    (Signed),
`ifdef BCD_HEX_BYPASS_EN
    .HexMode   (HexMode),
`endif
    .Busy      (Busy),
    .Done      (Done),
    .Disp_WE   (Disp_WE),
    .Disp_Addr (Disp_Addr),
    .Disp_WD   (Disp_WD)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [31:0] sign;
    int          wr_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain decimal digit extraction, latency by request class.
  function automatic exp_t model(input logic [31:0] v, input logic sgn, input logic hex);
    exp_t        e;
    logic        neg;
    logic [31:0] mag;
    longint      m;
    e.data = '0;
    e.sign = '0;
    e.wr_cyc = 1;
    if (hex) begin
      e.data = v;
      return e;
    end
    neg = sgn && v[31];
    m = neg ? (64'd4294967296 - longint'(v)) : longint'(v);
    mag = m[31:0];
    if (m > 99_999_999) begin
      e.sign = 32'h8;
      return e;
    end
    for (int i = 0; i < 8; i++) begin
      e.data[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    e.sign = neg ? 32'h1 : 32'h0;
    e.wr_cyc = 32;
    return e;
  endfunction

  // Wait for idle, issue one request; optionally record the expected response.
  task automatic issue(input logic [31:0] v, input logic sgn, input logic hex, input bit expect_it);
    exp_t e;
    int   n;
    n = 0;
    @(negedge Clock);
    while (Busy && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (Busy) begin
      tests++;
      fails++;
      $display("FAIL idle_wait: Busy stuck high, got 1 expected 0");
      return;
    end
    Value  = v;
    Signed = sgn;
`ifdef BCD_HEX_BYPASS_EN
    HexMode = hex;
`endif
    Start  = 1'b1;
    @(posedge Clock);
    #1;
    e = model(v, sgn, hex);
    e.wr_cyc = e.wr_cyc + cyc;
    if (expect_it) exp_q.push_back(e);
    @(negedge Clock);
    Start = 1'b0;
    Value = $urandom;
  endtask

  // Monitor: pairs each data write with the queued expectation, then the sign write and Done.
  exp_t cur;
  bit   have_cur = 0;
  bit   done_due = 0;
  bit   done_last = 0;

  always @(negedge Clock) begin
    if (Reset) begin
      have_cur  = 0;
      done_due  = 0;
      done_last = 0;
    end else begin
      if (Done) begin
        check("done_expected", 32'(done_due), 32'd1);
        check("done_single", 32'(done_last), 32'd0);
      end else if (done_due) begin
        check("done_missing", 32'd0, 32'd1);
      end
      done_last = Done;
      done_due  = 0;
      if (Disp_WE && !Disp_Addr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", Disp_WD, 32'hDEAD_BEEF);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          check("data_word", Disp_WD, cur.data);
          check("data_latency", 32'(cyc), 32'(cur.wr_cyc));
        end
      end else if (Disp_WE && Disp_Addr) begin
        if (!have_cur) begin
          check("orphan_sign_write", Disp_WD, 32'hDEAD_BEEF);
        end else begin
          check("sign_word", Disp_WD, cur.sign);
          check("sign_latency", 32'(cyc), 32'(cur.wr_cyc + 1));
          have_cur = 0;
          done_due = 1;
        end
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 32'(Busy), 32'd0);
    check({name, "_done"}, 32'(Done), 32'd0);
    check({name, "_we"},   32'(Disp_WE), 32'd0);
    check({name, "_addr"}, 32'(Disp_Addr), 32'd0);
    check({name, "_wd"},   Disp_WD, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int          n;
    Reset  = 1'b1;
    Start  = 1'b0;
    Value  = '0;
    Signed = 1'b0;
`ifdef BCD_HEX_BYPASS_EN
    HexMode = 1'b0;
`endif
    repeat (3) @(negedge Clock);
    check_idle_outputs("reset");
    Reset = 1'b0;

    issue(32'd1234, 1'b0, 1'b0, 1);
    issue(32'hFFFF_FFFB, 1'b1, 1'b0, 1);
    issue(32'd99_999_999, 1'b0, 1'b0, 1);
    issue(32'd100_000_000, 1'b0, 1'b0, 1);
    issue(32'h8000_0000, 1'b1, 1'b0, 1);
    issue(32'h8000_0000, 1'b0, 1'b0, 1);
    issue(32'd0, 1'b1, 1'b0, 1);
    issue(-32'sd99_999_999, 1'b1, 1'b0, 1);
    issue(-32'sd100_000_000, 1'b1, 1'b0, 1);
    issue(32'hFFFF_FFFF, 1'b1, 1'b0, 1);

    // Start during CONV with a new Value must be ignored.
    issue(32'd87_654_321, 1'b0, 1'b0, 1);
    repeat (8) @(negedge Clock);
    Value = 32'd5;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;

    // Reset mid-conversion: no writes, idle outputs right after.
    issue(32'd4321, 1'b0, 1'b0, 0);
    repeat (13) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check_idle_outputs("midconv_reset");
    Reset = 1'b0;
    issue(32'd4321, 1'b0, 1'b0, 1);

`ifdef BCD_HEX_BYPASS_EN
    issue(32'hCAFE_F00D, 1'b1, 1'b1, 1);
    issue(32'h0000_ABCD, 1'b0, 1'b1, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom_range(0, 9999);
        1: v = $urandom_range(99_999_900, 100_000_100);
        2: v = 32'd0 - $urandom_range(0, 100_000_100);
        default: v = $urandom;
      endcase
`ifdef BCD_HEX_BYPASS_EN
      issue(v, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1);
`else
      issue(v, 1'($urandom_range(0, 1)), 1'b0, 1);
`endif
    end

    n = 0;
    while ((exp_q.size() != 0 || have_cur || Busy) && n < 200) begin
      @(negedge Clock);
      n++;
    end
    repeat (3) @(negedge Clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(Busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
